// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN input row packer.
package cnn_pkg;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned COLS  = 26;
  localparam int unsigned ROWS  = 26;
  localparam int unsigned ROW_W = COLS * PIX_W;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 5;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_e;

  typedef struct packed {
    row_t row;
    logic last;
    cnt_t idx;
  } entry_t;
endpackage

// File: rtl/cnn_row_packer_if.sv
// Pixel-in / packed-row-out handshake bundle for cnn_row_packer.
interface cnn_row_packer_if;
  import cnn_pkg::*;

  logic [PIX_W-1:0] s_pix;
  logic             s_valid;
  logic             s_sof;
  logic             s_ready;
  row_t             m_row;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  cnt_t             row_idx;

  // Source of pixels and sink of rows
  modport master (
    output s_pix, s_valid, s_sof, m_ready,
    input  s_ready, m_row, m_valid, m_last, row_idx
  );

  // The packer itself
  modport slave (
    input  s_pix, s_valid, s_sof, m_ready,
    output s_ready, m_row, m_valid, m_last, row_idx
  );
endinterface

// File: rtl/cnn_row_fifo2.sv
// Two-entry packed-row FIFO; head held in a register so outputs are flop-driven.
module cnn_row_fifo2
  import cnn_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   valid,
  output logic   full
);

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;

  // Shift-style storage: entry 0 is always the head, entry 1 the one behind it
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign valid = (count_q != 2'd0);
  assign full  = (count_q == 2'(DEPTH));

endmodule

// File: rtl/cnn_row_packer.sv
// Packs a 26x26 8-bit pixel stream into 208-bit row words for conv layer 1.
module cnn_row_packer
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  cnn_row_packer_if.slave   bus,
  output logic              frame_done,
  output logic              err_pulse
);

  state_e state_q, state_d;
  cnt_t   col_q, col_d;
  cnt_t   row_q, row_d;
  row_t   asm_q, asm_d;
  logic   alive_q, alive_d;
  logic   err_q, err_d;
  logic   fd_q, fd_d;

  logic   s_ready;
  logic   acc;
  logic   pop;
  logic   push;
  entry_t push_data;
  entry_t head;
  logic   fifo_valid;
  logic   fifo_full;

  // Ready depends only on local state, never on m_ready
  always_comb begin
    s_ready = en & alive_q &
              !((state_q == PACK) && (col_q == cnt_t'(COLS-1)) && fifo_full);
    acc     = bus.s_valid & s_ready;
    pop     = en & fifo_valid & bus.m_ready;
  end

  // Packer FSM: next state, assembly register and push request
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    asm_d     = asm_q;
    alive_d   = 1'b1;
    err_d     = 1'b0;
    push      = 1'b0;
    if (acc) begin
      if (bus.s_sof) begin
        // SOF mid-frame restarts the frame; queued rows are left alone
        err_d            = (state_q == PACK);
        asm_d[PIX_W-1:0] = bus.s_pix;
        col_d            = cnt_t'(1);
        row_d            = '0;
        state_d          = PACK;
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        asm_d[int'(col_q)*PIX_W +: PIX_W] = bus.s_pix;
        if (col_q == cnt_t'(COLS-1)) begin
          push  = 1'b1;
          col_d = '0;
          if (row_q == cnt_t'(ROWS-1)) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + cnt_t'(1);
          end
        end else begin
          col_d = col_q + cnt_t'(1);
        end
      end
    end
    push_data.row  = asm_d;
    push_data.last = (row_q == cnt_t'(ROWS-1));
    push_data.idx  = row_q;
    fd_d           = pop & head.last;
  end

  // Packer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      asm_q   <= '0;
      alive_q <= 1'b0;
      err_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      asm_q   <= asm_d;
      alive_q <= alive_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
    end
  end

  cnn_row_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign bus.s_ready = s_ready;
  assign bus.m_row   = head.row;
  assign bus.m_last  = head.last;
  assign bus.row_idx = head.idx;
  assign bus.m_valid = fifo_valid;
  assign frame_done  = fd_q;
  assign err_pulse   = err_q;

endmodule
